uart_rx_os: RTL

- Next-generation UART receiver.
- Adds runtime-configurable baud divisor, 16x oversampling with 3-sample majority vote, and data width 5..DataWidthMax.
- Adds optional even/odd parity, 1 or 2 stop bits, per-frame framing/parity error flags, and break detection.
- Sits between the raw pad input and the RX FIFO; presents words on a valid/ready output; reports lost words through a sticky overrun flag.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_os.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  // Narrowest data field the receiver accepts.
  localparam int MinDataBits = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_e;

  // Frame format captured at start detection and held for the whole frame.
  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_even;
    logic       stop2;
  } uart_rx_cfg_t;

  // Keeps a requested data width inside MinDataBits..max_bits so the shift
  // logic never indexes outside the data register.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                 input logic [3:0] max_bits);
    logic [3:0] r;
    r = bits;
    if (bits < 4'(MinDataBits)) r = 4'(MinDataBits);
    else if (bits > max_bits)   r = max_bits;
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one tick every (i_div + 1) enabled clocks.
module uart_baud_tick #(
  parameter int DivWidth = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic                i_clr,
  input  logic [DivWidth-1:0] i_div,
  output logic                o_tick
);

  logic [DivWidth-1:0] cnt_q;

  // Compare with >= so that lowering the divisor below the current count
  // wraps at once instead of running through the whole counter range.
  assign o_tick = i_en && (cnt_q >= i_div);

  // Divisor counter: clears on request, wraps after the tick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= o_tick ? '0 : cnt_q + DivWidth'(1);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with 16x oversampling, majority vote, parity/stop checking,
// break detection and a valid/ready output with sticky overrun.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DataWidthMax = 9,
  parameter int OverSample   = 16,
  parameter int DivWidth     = 16,
  parameter int SyncStages   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx,
  input  logic                    i_en,
  input  logic [DivWidth-1:0]     i_cfg_div,
  input  logic [3:0]              i_cfg_data_bits,
  input  logic                    i_cfg_parity_en,
  input  logic                    i_cfg_parity_even,
  input  logic                    i_cfg_stop2,
  input  logic                    i_ready,
  input  logic                    i_clr,
  output logic [DataWidthMax-1:0] o_data,
  output logic                    o_valid,
  output logic                    o_frame_err,
  output logic                    o_parity_err,
  output logic                    o_break,
  output logic                    o_overrun,
  output logic                    o_busy
);

  localparam int OsW = $clog2(OverSample);
  localparam logic [OsW-1:0] SampA  = OsW'(OverSample / 2 - 1);
  localparam logic [OsW-1:0] SampB  = OsW'(OverSample / 2);
  localparam logic [OsW-1:0] SampC  = OsW'(OverSample / 2 + 1);
  localparam logic [OsW-1:0] OsLast = OsW'(OverSample - 1);

  logic [SyncStages-1:0]   sync_q;
  logic                    rx_s;
  rx_state_e               state_q, state_d;
  uart_rx_cfg_t            cfg_q;
  logic [DivWidth-1:0]     div_q, div_eff;
  logic                    tick;
  logic [OsW-1:0]          os_cnt_q;
  logic                    samp_a_q, samp_b_q;
  logic [3:0]              bit_idx_q;
  logic [DataWidthMax-1:0] data_q;
  logic                    par_bit_q, stop_idx_q, ferr_q;

  logic maj, at_sample, last_data, is_break, par_exp;
  logic start_det, shift_en, par_cap, stop_cap, frame_done, break_det;

  // Input synchroniser; flops reset high so the idle line never looks like a start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '1;
    else          sync_q <= {sync_q[SyncStages-2:0], i_rx};
  end
  assign rx_s = sync_q[SyncStages-1];

  // While idle the live divisor drives the tick; during a frame the latched one.
  assign div_eff = (state_q == IDLE) ? i_cfg_div : div_q;

  uart_baud_tick #(.DivWidth(DivWidth)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_clr   (!i_en),
    .i_div   (div_eff),
    .o_tick  (tick)
  );

  // Third sample is the live synced input on the deciding tick.
  assign maj       = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
  assign at_sample = tick && (os_cnt_q == SampC);
  assign last_data = (bit_idx_q == cfg_q.data_bits - 4'd1);
  assign par_exp   = (^data_q) ^ ~cfg_q.parity_even;
  // Break is judged on the first stop bit only: all-zero data, zero parity bit.
  assign is_break  = (data_q == '0) && !(cfg_q.parity_en && par_bit_q) && !maj && !stop_idx_q;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (tick && !rx_s) state_d = START;
      START:      if (at_sample) state_d = maj ? IDLE : DATA;
      DATA:       if (at_sample && last_data) state_d = cfg_q.parity_en ? PARITY : STOP;
      PARITY:     if (at_sample) state_d = STOP;
      STOP: begin
        if (at_sample) begin
          if (is_break)                       state_d = BREAK_WAIT;
          else if (cfg_q.stop2 && !stop_idx_q) state_d = STOP;
          else                                 state_d = IDLE;
        end
      end
      BREAK_WAIT: if (tick && rx_s) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (!i_en) state_d = IDLE;
  end

  // FSM output strobes steering the datapath.
  always_comb begin
    start_det  = 1'b0;
    shift_en   = 1'b0;
    par_cap    = 1'b0;
    stop_cap   = 1'b0;
    frame_done = 1'b0;
    break_det  = 1'b0;
    case (state_q)
      IDLE:   start_det = tick && !rx_s;
      DATA:   shift_en  = at_sample;
      PARITY: par_cap   = at_sample;
      STOP: begin
        if (at_sample) begin
          stop_cap = 1'b1;
          if (is_break)                         break_det  = 1'b1;
          else if (!cfg_q.stop2 || stop_idx_q) frame_done = 1'b1;
        end
      end
      default: ;
    endcase
  end
  assign o_busy = (state_q != IDLE);

  // Per-frame datapath: config latch, bit-phase counter, shifter, stop tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_q      <= '0;
      div_q      <= '0;
      os_cnt_q   <= '0;
      bit_idx_q  <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      stop_idx_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (start_det) begin
      cfg_q.data_bits   <= clamp_data_bits(i_cfg_data_bits, 4'(DataWidthMax));
      cfg_q.parity_en   <= i_cfg_parity_en;
      cfg_q.parity_even <= i_cfg_parity_even;
      cfg_q.stop2       <= i_cfg_stop2;
      div_q             <= i_cfg_div;
      // The detecting tick is tick 0 of the start bit; the next one is tick 1.
      os_cnt_q          <= OsW'(1);
      bit_idx_q         <= '0;
      data_q            <= '0;
      stop_idx_q        <= 1'b0;
      ferr_q            <= 1'b0;
    end else begin
      if (tick && state_q != IDLE)
        os_cnt_q <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
      if (shift_en) begin
        for (int i = 0; i < DataWidthMax; i++)
          if (bit_idx_q == 4'(i)) data_q[i] <= maj;
        bit_idx_q <= bit_idx_q + 4'd1;
      end
      if (par_cap) par_bit_q <= maj;
      if (stop_cap) begin
        stop_idx_q <= 1'b1;
        if (!maj) ferr_q <= 1'b1;
      end
    end
  end

  // First two majority samples of the current bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else if (tick) begin
      if (os_cnt_q == SampA) samp_a_q <= rx_s;
      if (os_cnt_q == SampB) samp_b_q <= rx_s;
    end
  end

  // Output word register with valid/ready handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else if (frame_done && (!o_valid || i_ready)) begin
      o_data       <= data_q;
      o_valid      <= 1'b1;
      o_frame_err  <= ferr_q | !maj;
      o_parity_err <= cfg_q.parity_en && (par_bit_q != par_exp);
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Sticky overrun; a new discard outranks a clear in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             o_overrun <= 1'b0;
    else if (frame_done && o_valid && !i_ready) o_overrun <= 1'b1;
    else if (i_clr)                           o_overrun <= 1'b0;
  end

  // One-cycle break pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_break <= 1'b0;
    else          o_break <= break_det;
  end

endmodule
